// File: rtl/bcd_pkg.sv
// Shared constants and types for the BCD conversion/arithmetic blocks.
package bcd_pkg;

  localparam int BCD_DIGIT_W    = 4;
  localparam int BCD_ADJ_THRESH = 5;
  localparam int BCD_ADJ_VAL    = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Constant function used at elaboration to size-check DIGITS against WIDTH.
  function automatic longint bcd_pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a digit of 5..9 is bumped by 3 so the next
// left shift carries cleanly into the neighbouring decimal digit.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] dig_i,
  output logic [BCD_DIGIT_W-1:0] dig_o
);

  always_comb begin
    dig_o = dig_i;
    if (dig_i >= BCD_DIGIT_W'(BCD_ADJ_THRESH)) dig_o = dig_i + BCD_DIGIT_W'(BCD_ADJ_VAL);
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock,
// framed by a start/ready/busy/done handshake.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [WIDTH-1:0]              bin,
  output logic                          ready,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd
);

  localparam int BCD_W  = BCD_DIGIT_W * DIGITS;
  localparam int WORK_W = BCD_W + WIDTH;
  localparam int CNT_W  = $clog2(WIDTH + 1);

  if (!(bcd_pow10(DIGITS) > ((longint'(1) << WIDTH) - 1))) begin : g_size_check
    $fatal(1, "bin_to_bcd_seq: DIGITS too small to hold 2^WIDTH-1");
  end

  state_t              state_q, state_d;
  logic [WORK_W-1:0]   work_q, work_d;
  logic [WORK_W-1:0]   work_adj, work_shl;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic                done_q, done_d;

  // Only the decimal digit fields above the binary bits get corrected.
  assign work_adj[WIDTH-1:0] = work_q[WIDTH-1:0];
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .dig_i (work_q  [WIDTH + g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dig_o (work_adj[WIDTH + g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign work_shl = work_adj << 1;

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = {{BCD_W{1'b0}}, bin};
          cnt_d   = CNT_W'(WIDTH);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        work_d = work_shl;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = work_shl[WORK_W-1 -: BCD_W];
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
    end
  end

  assign busy  = (state_q == SHIFT);
  assign ready = ~busy;
  assign done  = done_q;
  assign bcd   = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Randomised and directed bench for bin_to_bcd_seq against an arithmetic
// decimal-digit reference model.
module tb_bin_to_bcd_seq;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;

  logic                  clk;
  logic                  rst;
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  ready;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;

  int total;
  int bad;
  int done_cnt;
  logic prev_busy;
  logic prev_done;
  logic [4*DIGITS-1:0] prev_bcd;

  bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Decimal digits by division, packed one nibble per digit.
  function automatic logic [31:0] ref_bcd(input int v);
    logic [31:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Protocol monitor: bcd frozen during a conversion, done one cycle wide.
  always @(negedge clk) begin
    if (rst) begin
      prev_busy = 1'b0;
      prev_done = 1'b0;
    end else begin
      chk("ready_vs_busy", ready, !busy);
      if (busy && prev_busy) chk("bcd_hold", bcd, prev_bcd);
      if (prev_done) chk("done_width", done, 1'b0);
      if (done) done_cnt++;
      prev_busy = busy;
      prev_done = done;
      prev_bcd  = bcd;
    end
  end

  task automatic launch(input int v);
    @(negedge clk);
    chk("ready_before_start", ready, 1'b1);
    start = 1'b1;
    bin   = WIDTH'(v);
  endtask

  // Waits for done; n counts negedges after the accepting edge. Optionally
  // re-pulses start with poke_v at negedge poke_at.
  task automatic wait_done(input int poke_at, input int poke_v,
                           output logic [31:0] res, output int lat);
    lat = 0;
    res = '0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      start = (n == poke_at);
      if (n == poke_at) bin = WIDTH'(poke_v);
      if (n == 1) chk("busy_after_accept", busy, 1'b1);
      if (done) begin
        lat = n;
        res = 32'(bcd);
        return;
      end
    end
    chk("done_timeout", lat, WIDTH + 1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic convert(input int v, input string tag);
    logic [31:0] res;
    int lat;
    launch(v);
    wait_done(0, 0, res, lat);
    chk(tag, res, ref_bcd(v));
    chk("latency", lat, WIDTH + 1);
  endtask

  initial begin
    logic [31:0] res;
    int lat;
    int dc;
    int basics[5];
    total    = 0;
    bad      = 0;
    done_cnt = 0;
    rst      = 1'b1;
    start    = 1'b0;
    bin      = '0;
    basics   = '{0, 9, 10, 128, 255};

    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_bcd", bcd, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (basics[i]) convert(basics[i], "basic");

    // Reset mid-conversion aborts without a done pulse.
    launch(200);
    idle_cycles(4);
    dc = done_cnt;
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_ready", ready, 1'b1);
    chk("abort_bcd", bcd, 0);
    chk("abort_done", done, 1'b0);
    idle_cycles(2);
    rst = 1'b0;
    idle_cycles(12);
    chk("abort_no_done", done_cnt, dc);
    convert(200, "after_reset");

    // start while busy is ignored.
    launch(99);
    dc = done_cnt;
    wait_done(3, 7, res, lat);
    chk("ignored_start_res", res, 32'h099);
    chk("ignored_start_lat", lat, WIDTH + 1);
    idle_cycles(14);
    chk("ignored_start_busy", busy, 1'b0);
    chk("ignored_start_ndone", done_cnt - dc, 1);

    // Back-to-back: start accepted in the done cycle.
    launch(37);
    wait_done(0, 0, res, lat);
    chk("b2b_first", res, 32'h037);
    start = 1'b1;
    bin   = WIDTH'(64);
    wait_done(0, 0, res, lat);
    chk("b2b_second", res, 32'h064);
    chk("b2b_latency", lat, WIDTH + 1);

    // Downstream Excess-3 view of 255.
    launch(255);
    wait_done(0, 0, res, lat);
    chk("xs3_d0", 4'(res[3:0] + 4'd3), 4'b1000);
    chk("xs3_d1", 4'(res[7:4] + 4'd3), 4'b1000);
    chk("xs3_d2", 4'(res[11:8] + 4'd3), 4'b0101);

    for (int v = 0; v < (1 << WIDTH); v++) convert(v, "sweep");
    for (int k = 0; k < 40; k++) convert(int'($urandom_range(0, (1 << WIDTH) - 1)), "random");

    idle_cycles(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
